// File: rtl/multi_flux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_flux_pkg
// Purpose  : Shared constants and token helpers for the multi-flux FIFO.
// Revision : 1.0
// ============================================================================
package multi_flux_pkg;

  localparam int DEF_FLUX       = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int TOKEN_MAX_W    = 64;

  // A single-flux build still carries a one-bit tag.
  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic logic [31:0] token_tag(input logic [TOKEN_MAX_W-1:0] tok,
                                            input int data_w,
                                            input int tag_w);
    logic [TOKEN_MAX_W-1:0] mask;
    mask = (TOKEN_MAX_W'(1) << tag_w) - TOKEN_MAX_W'(1);
    return 32'((tok >> data_w) & mask);
  endfunction

  function automatic logic [TOKEN_MAX_W-1:0] token_payload(input logic [TOKEN_MAX_W-1:0] tok,
                                                           input int data_w);
    return tok & ((TOKEN_MAX_W'(1) << data_w) - TOKEN_MAX_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/flux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : flux_fifo
// Purpose  : Single-flux circular FIFO with registered count, full and empty.
// Revision : 1.0
// ============================================================================
module flux_fifo
  import multi_flux_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/multi_flux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : multi_flux_fifo
// Purpose  : Per-flux tagged FIFOs with round-robin registered output.
//            Optional drop counter enabled by MULTI_FLUX_FIFO_DROP_CNT_EN.
// Revision : 1.0
// ============================================================================
module multi_flux_fifo
  import multi_flux_pkg::*;
#(
  parameter int FLUX       = DEF_FLUX,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = tag_width(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_port_write,
  input  logic [WIDTH-1:0] in_port_datain,
  output logic [FLUX-1:0]  in_port_full,
  output logic             out_port_write,
  output logic [WIDTH-1:0] out_port_dataout,
  input  logic             out_port_full
`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  logic [TAG_WIDTH-1:0] tag;
  logic [FLUX-1:0]      push_vec;
  logic [FLUX-1:0]      pop_vec;
  logic [FLUX-1:0]      full_vec;
  logic [FLUX-1:0]      empty_vec;
  logic [WIDTH-1:0]     fifo_dout [FLUX];
  logic                 found;
  int                   gnt;

  logic [TAG_WIDTH-1:0] rr_q, rr_d;
  logic                 out_write_q, out_write_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;

  for (genvar k = 0; k < FLUX; k++) begin : g_flux
    flux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[k]),
      .pop   (pop_vec[k]),
      .din   (in_port_datain),
      .dout  (fifo_dout[k]),
      .full  (full_vec[k]),
      .empty (empty_vec[k])
    );
  end

  // Out-of-range tags match no flux and therefore fall through as drops.
  always_comb begin
    tag = TAG_WIDTH'(token_tag(TOKEN_MAX_W'(in_port_datain), DATA_WIDTH, TAG_WIDTH));
    for (int k = 0; k < FLUX; k++) begin
      push_vec[k] = in_port_write && (tag == TAG_WIDTH'(k)) && !full_vec[k];
    end
  end

  // Two passes: first the fluxes at or above the priority pointer, then wrap.
  always_comb begin
    found = 1'b0;
    gnt   = 0;
    if (!out_port_full) begin
      for (int k = 0; k < FLUX; k++) begin
        if (!found && !empty_vec[k] && (k >= int'(rr_q))) begin
          found = 1'b1;
          gnt   = k;
        end
      end
      for (int k = 0; k < FLUX; k++) begin
        if (!found && !empty_vec[k]) begin
          found = 1'b1;
          gnt   = k;
        end
      end
    end
  end

  always_comb begin
    pop_vec     = '0;
    out_data_d  = out_data_q;
    out_write_d = found;
    rr_d        = rr_q;
    for (int k = 0; k < FLUX; k++) begin
      if (found && (gnt == k)) begin
        pop_vec[k] = 1'b1;
        out_data_d = fifo_dout[k];
      end
    end
    if (found) rr_d = TAG_WIDTH'((gnt + 1 >= FLUX) ? 0 : gnt + 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q        <= '0;
      out_write_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      out_write_q <= out_write_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_port_full     = full_vec;
  assign out_port_write   = out_write_q;
  assign out_port_dataout = out_data_q;

`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = in_port_write && (push_vec == '0);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_flux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_flux_fifo
// Purpose  : Self-checking bench for multi_flux_fifo (FLUX=2, DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_multi_flux_fifo;

  localparam int FL = 2;
  localparam int DW = 8;
  localparam int TW = 1;
  localparam int W  = DW + TW;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic          in_write;
  logic [W-1:0]  in_data;
  logic [FL-1:0] in_full;
  logic          out_write;
  logic [W-1:0]  out_data;
  logic          out_full;
`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per flux plus a round-robin pointer.
  logic [W-1:0] mq [FL][$];
  int           m_rr;
  logic         m_write;
  logic [W-1:0] m_data;
  int           m_drops;

  typedef struct {
    logic         wr;
    logic [W-1:0] din;
    logic         ofull;
    logic         exp_write;
    logic [W-1:0] exp_data;
    logic [FL-1:0] exp_full;
  } vec_t;
  vec_t vecs [6];

  multi_flux_fifo #(
    .FLUX       (FL),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .WIDTH      (W),
    .DEPTH      (DP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_port_write    (in_write),
    .in_port_datain   (in_data),
    .in_port_full     (in_full),
    .out_port_write   (out_write),
    .out_port_dataout (out_data),
    .out_port_full    (out_full)
`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < FL; k++) mq[k].delete();
    m_rr    = 0;
    m_write = 1'b0;
    m_data  = '0;
    m_drops = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [W-1:0] din, input logic ofull);
    int  sz [FL];
    int  t;
    bit  popped;
    popped = 1'b0;
    for (int k = 0; k < FL; k++) sz[k] = mq[k].size();
    m_write = 1'b0;
    if (!ofull) begin
      for (int i = 0; i < FL; i++) begin
        int k;
        k = (m_rr + i) % FL;
        if (!popped && sz[k] > 0) begin
          m_data  = mq[k].pop_front();
          m_write = 1'b1;
          m_rr    = (k + 1) % FL;
          popped  = 1'b1;
        end
      end
    end
    t = int'(din[W-1 -: TW]);
    if (wr) begin
      if (t < FL && sz[t] < DP) mq[t].push_back(din);
      else if (m_drops < 65535) m_drops++;
    end
  endtask

  task automatic compare_model();
    logic [FL-1:0] ef;
    for (int k = 0; k < FL; k++) ef[k] = (mq[k].size() == DP);
    check("model_write", 32'(out_write), 32'(m_write));
    check("model_data",  32'(out_data),  32'(m_data));
    check("model_full",  32'(in_full),   32'(ef));
`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
    check("model_drops", 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  // Called #1 after a rising edge; drives, crosses the next edge, then compares.
  task automatic apply(input logic wr, input logic [W-1:0] din, input logic ofull);
    in_write = wr;
    in_data  = din;
    out_full = ofull;
    @(posedge clk);
    model_edge(wr, din, ofull);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    in_write = 1'b0;
    out_full = 1'b0;
    rst      = 1'b0;
    #1;
    model_reset();
    check("rst_write", 32'(out_write), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_full",  32'(in_full),   32'd0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    in_write = 1'b0;
    in_data  = '0;
    out_full = 1'b0;
    model_reset();

    vecs[0] = '{1'b1, 9'h001, 1'b0, 1'b0, 9'h000, 2'b00};
    vecs[1] = '{1'b1, 9'h101, 1'b0, 1'b1, 9'h001, 2'b00};
    vecs[2] = '{1'b1, 9'h102, 1'b0, 1'b1, 9'h101, 2'b00};
    vecs[3] = '{1'b1, 9'h003, 1'b0, 1'b1, 9'h102, 2'b00};
    vecs[4] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h003, 2'b00};
    vecs[5] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h003, 2'b00};

    #3;
    check("init_write", 32'(out_write), 32'd0);
    check("init_data",  32'(out_data),  32'd0);
    check("init_full",  32'(in_full),   32'd0);
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Mid-stream reset with three tokens still buffered.
    for (int i = 0; i < 4; i++) apply(1'b1, {1'b0, 8'(8'h20 + i)}, 1'b1);
    check("pre_rst_full", 32'(in_full), 32'h1);
    apply(1'b0, '0, 1'b0);
    check("pre_rst_write", 32'(out_write), 32'd1);
    check("pre_rst_data",  32'(out_data),  32'h020);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b0);
      check("post_rst_quiet", 32'(out_write), 32'd0);
    end

    // Order, tag and round-robin table.
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].wr, vecs[i].din, vecs[i].ofull);
      check("vec_write", 32'(out_write), 32'(vecs[i].exp_write));
      check("vec_data",  32'(out_data),  32'(vecs[i].exp_data));
      check("vec_full",  32'(in_full),   32'(vecs[i].exp_full));
    end

    // Latency: push into an empty block is visible only after the following edge.
    apply(1'b1, 9'h155, 1'b0);
    check("lat_t", 32'(out_write), 32'd0);
    apply(1'b0, '0, 1'b0);
    check("lat_t1_write", 32'(out_write), 32'd1);
    check("lat_t1_data",  32'(out_data),  32'h155);

    // Backpressure: fifth flux-0 token dropped.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, {1'b0, 8'(8'h0A + i)}, 1'b1);
      if (i >= 3) check("bp_full", 32'(in_full), 32'h1);
      else        check("bp_notfull", 32'(in_full), 32'h0);
    end
`ifdef MULTI_FLUX_FIFO_DROP_CNT_EN
    check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b0);
      check("bp_drain_write", 32'(out_write), 32'd1);
      check("bp_drain_data",  32'(out_data),  32'(9'h00A + i));
    end
    apply(1'b0, '0, 1'b0);
    check("bp_drain_done", 32'(out_write), 32'd0);

    // Isolation: flux 0 full does not block flux 1.
    for (int i = 0; i < 4; i++) apply(1'b1, {1'b0, 8'(8'h40 + i)}, 1'b1);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, {1'b1, 8'(8'h50 + i)}, 1'b1);
      check("iso_full", 32'(in_full), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, {1'b1, 8'(8'h60 + i)}, 1'b0);
      if (i == 0) check("iso_first", 32'(out_data), 32'h150);
      if (i == 1) check("iso_second", 32'(out_data), 32'h040);
    end
    for (int i = 0; i < 10; i++) apply(1'b0, '0, 1'b0);

    // Simultaneous push and pop on a full flux 1.
    for (int i = 0; i < 4; i++) apply(1'b1, {1'b1, 8'(8'h70 + i)}, 1'b1);
    check("sim_full_before", 32'(in_full), 32'h2);
    apply(1'b1, 9'h17F, 1'b0);
    check("sim_full_after", 32'(in_full), 32'h0);
    check("sim_pop_data",   32'(out_data), 32'h170);
    apply(1'b1, 9'h17E, 1'b1);
    check("sim_refill", 32'(in_full), 32'h2);
    for (int i = 0; i < 6; i++) apply(1'b0, '0, 1'b0);

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      apply(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
